ook_rx: RTL and testbench

//   On-off-keyed (OOK) RF receiver/demodulator, the receive end of the gated-carrier rf link.

---
 rtl/ook_rx_if.sv | 24 ++
 rtl/ook_rx.sv | 170 +++++++++++++++++
 tb/tb_ook_rx.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ook_rx_if.sv
// Output bundle of the OOK receiver: demodulated byte, its strobes and link status.
interface ook_rx_if;
   logic       carrier;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       busy;

   modport master (
      output carrier,
      output data,
      output data_valid,
      output frame_err,
      output busy
   );

   modport slave (
      input carrier,
      input data,
      input data_valid,
      input frame_err,
      input busy
   );
endinterface

// File: rtl/ook_rx.sv
// OOK demodulator: counts envelope edges per window to detect carrier, then
// frames slot majority votes into start/8 data LSB-first/stop bytes.
module ook_rx #(
   parameter int WIN_LEN     = 256,
   parameter int EDGE_THRESH = 16,
   parameter int BIT_WINDOWS = 8
) (
   input  logic      CLK1,
   input  logic      RST,
   input  logic      rf_in,
   ook_rx_if.master  bus
);

   localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam int EW = $clog2(EDGE_THRESH + 1);
   localparam int SW = $clog2(BIT_WINDOWS + 1);

   localparam logic [WW-1:0] WIN_LAST    = WW'(WIN_LEN - 1);
   localparam logic [EW-1:0] THRESH_SAT  = EW'(EDGE_THRESH);
   localparam logic [EW:0]   THRESH_CMP  = (EW+1)'(EDGE_THRESH);
   localparam logic [SW-1:0] SLOT_LAST   = SW'(BIT_WINDOWS);
   localparam logic [SW-1:0] HALF_SLOT   = SW'(BIT_WINDOWS / 2);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [1:0]    r_sync;
   logic          r_prev;
   logic [WW-1:0] r_winCnt;
   logic [EW-1:0] r_edgeCnt;
   logic          r_carrier;
   logic          r_tick;
   state_t        r_state;
   logic [SW-1:0] r_slotCnt;
   logic [SW-1:0] r_onesCnt;
   logic [2:0]    r_bitIdx;
   logic [7:0]    r_shreg;
   logic [7:0]    r_data;
   logic          r_dataValid;
   logic          r_frameErr;
   logic          r_busy;

   logic          w_edge;
   logic          w_winEnd;
   logic [EW:0]   w_edgeTotal;
   logic [SW-1:0] w_onesNext;
   logic [SW-1:0] w_slotNext;
   logic          w_slotEnd;
   logic          w_bit;

   assign w_edge      = r_sync[1] & ~r_prev;
   assign w_winEnd    = (r_winCnt == WIN_LAST);
   assign w_edgeTotal = {1'b0, r_edgeCnt} + {{EW{1'b0}}, w_edge};
   assign w_onesNext  = r_onesCnt + {{(SW-1){1'b0}}, r_carrier};
   assign w_slotNext  = r_slotCnt + {{(SW-1){1'b0}}, 1'b1};
   assign w_slotEnd   = (w_slotNext == SLOT_LAST);
   // ones*2 > BIT_WINDOWS is the same as ones > floor(BIT_WINDOWS/2); ties vote 0
   assign w_bit       = (w_onesNext > HALF_SLOT);

   always_ff @(posedge CLK1 or posedge RST) begin
      if (RST) begin
         r_sync <= 2'b00;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], rf_in};
         r_prev <= r_sync[1];
      end
   end

   // An edge landing on the last window cycle is folded into that window's verdict
   always_ff @(posedge CLK1 or posedge RST) begin
      if (RST) begin
         r_winCnt  <= '0;
         r_edgeCnt <= '0;
         r_carrier <= 1'b0;
         r_tick    <= 1'b0;
      end else if (w_winEnd) begin
         r_winCnt  <= '0;
         r_edgeCnt <= '0;
         r_carrier <= (w_edgeTotal >= THRESH_CMP);
         r_tick    <= 1'b1;
      end else begin
         r_winCnt  <= r_winCnt + {{(WW-1){1'b0}}, 1'b1};
         r_tick    <= 1'b0;
         if (w_edge && (r_edgeCnt != THRESH_SAT))
            r_edgeCnt <= r_edgeCnt + {{(EW-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge CLK1 or posedge RST) begin
      if (RST) begin
         r_state     <= IDLE;
         r_slotCnt   <= '0;
         r_onesCnt   <= '0;
         r_bitIdx    <= 3'd0;
         r_shreg     <= 8'h00;
         r_data      <= 8'h00;
         r_dataValid <= 1'b0;
         r_frameErr  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_dataValid <= 1'b0;
         r_frameErr  <= 1'b0;
         if (r_tick) begin
            if (r_state != IDLE) begin
               r_slotCnt <= w_slotEnd ? '0 : w_slotNext;
               r_onesCnt <= w_slotEnd ? '0 : w_onesNext;
            end
            case (r_state)
               IDLE: begin
                  // The detecting window is already slot window 0 of the start bit
                  if (r_carrier) begin
                     r_busy <= 1'b1;
                     if (BIT_WINDOWS == 1) begin
                        r_state  <= DATA;
                        r_bitIdx <= 3'd0;
                     end else begin
                        r_state   <= START;
                        r_slotCnt <= {{(SW-1){1'b0}}, 1'b1};
                        r_onesCnt <= {{(SW-1){1'b0}}, 1'b1};
                     end
                  end
               end
               START: begin
                  if (w_slotEnd) begin
                     if (w_bit) begin
                        r_state  <= DATA;
                        r_bitIdx <= 3'd0;
                     end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                     end
                  end
               end
               DATA: begin
                  if (w_slotEnd) begin
                     r_shreg[r_bitIdx] <= w_bit;
                     if (r_bitIdx == 3'd7)
                        r_state <= STOP;
                     else
                        r_bitIdx <= r_bitIdx + 3'd1;
                  end
               end
               STOP: begin
                  if (w_slotEnd) begin
                     if (w_bit) begin
                        r_frameErr <= 1'b1;
                     end else begin
                        r_data      <= r_shreg;
                        r_dataValid <= 1'b1;
                     end
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.carrier    = r_carrier;
   assign bus.data       = r_data;
   assign bus.data_valid = r_dataValid;
   assign bus.frame_err  = r_frameErr;
   assign bus.busy       = r_busy;

endmodule

// File: tb/tb_ook_rx.sv
// Directed bench for ook_rx with 16-cycle windows, 4-edge threshold and 4 windows per bit.
module tb_ook_rx;

   localparam int WIN_LEN     = 16;
   localparam int EDGE_THRESH = 4;
   localparam int BIT_WINDOWS = 4;

   localparam logic [15:0] PAT_ON    = 16'h3333;
   localparam logic [15:0] PAT_OFF   = 16'h0000;
   localparam logic [15:0] PAT_3EDGE = 16'h0333;
   localparam logic [15:0] PAT_3LATE = 16'h0666;
   localparam logic [15:0] PAT_4LATE = 16'h6666;

   logic CLK1 = 1'b0;
   logic RST  = 1'b1;
   logic rf_in = 1'b0;

   ook_rx_if bus ();

   ook_rx #(
      .WIN_LEN(WIN_LEN),
      .EDGE_THRESH(EDGE_THRESH),
      .BIT_WINDOWS(BIT_WINDOWS)
   ) dut (
      .CLK1(CLK1),
      .RST(RST),
      .rf_in(rf_in),
      .bus(bus)
   );

   always #5 CLK1 = ~CLK1;

   int passCnt  = 0;
   int totalCnt = 0;
   int validCnt = 0;
   int errCnt   = 0;
   int busyCnt  = 0;
   int tbPh     = 0;

   // Bench's own window phase: mirrors where a window starts after reset release
   always @(posedge CLK1 or posedge RST) begin
      if (RST) tbPh <= 0;
      else     tbPh <= (tbPh == WIN_LEN - 1) ? 0 : tbPh + 1;
   end

   always @(negedge CLK1) begin
      if (bus.data_valid === 1'b1) validCnt <= validCnt + 1;
      if (bus.frame_err  === 1'b1) errCnt   <= errCnt + 1;
      if (bus.busy       === 1'b1) busyCnt  <= busyCnt + 1;
   end

   task automatic alignWindow();
      @(negedge CLK1);
      for (int i = 0; i < WIN_LEN && tbPh != 0; i++) @(negedge CLK1);
   endtask

   // Called at a negedge with tbPh==0; rises driven at c drop into the window at c+2
   task automatic sendPattern(input logic [15:0] p);
      for (int c = 0; c < WIN_LEN; c++) begin
         rf_in = p[c];
         @(negedge CLK1);
      end
   endtask

   task automatic sendSlot(input logic on);
      for (int w = 0; w < BIT_WINDOWS; w++) sendPattern(on ? PAT_ON : PAT_OFF);
   endtask

   task automatic sendFrame(input logic [7:0] b, input logic stopOn);
      sendSlot(1'b1);
      for (int i = 0; i < 8; i++) sendSlot(b[i]);
      sendSlot(stopOn);
   endtask

   task automatic idleWindows(input int n);
      alignWindow();
      for (int w = 0; w < n; w++) sendPattern(PAT_OFF);
   endtask

   task automatic test_reset();
      rf_in = 1'b0;
      RST   = 1'b1;
      repeat (3) @(negedge CLK1);
      totalCnt++;
      if (bus.carrier !== 1'b0) $display("[TB] FAIL reset_carrier got %b want 0", bus.carrier);
      else passCnt++;
      totalCnt++;
      if (bus.data !== 8'h00) $display("[TB] FAIL reset_data got %h want 00", bus.data);
      else passCnt++;
      totalCnt++;
      if (bus.data_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", bus.data_valid);
      else passCnt++;
      totalCnt++;
      if (bus.frame_err !== 1'b0) $display("[TB] FAIL reset_err got %b want 0", bus.frame_err);
      else passCnt++;
      totalCnt++;
      if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", bus.busy);
      else passCnt++;
      RST = 1'b0;
   endtask

   task automatic test_static(input logic level);
      int sawCarrier = 0;
      int sawBusy    = 0;
      int v0, e0;
      v0 = validCnt;
      e0 = errCnt;
      rf_in = level;
      for (int i = 0; i < 2000; i++) begin
         @(negedge CLK1);
         if (bus.carrier === 1'b1) sawCarrier++;
         if (bus.busy === 1'b1) sawBusy++;
      end
      totalCnt++;
      if (sawCarrier !== 0) $display("[TB] FAIL static%0b_carrier got %0d high cycles want 0", level, sawCarrier);
      else passCnt++;
      totalCnt++;
      if (sawBusy !== 0) $display("[TB] FAIL static%0b_busy got %0d high cycles want 0", level, sawBusy);
      else passCnt++;
      totalCnt++;
      if ((validCnt - v0) + (errCnt - e0) !== 0)
         $display("[TB] FAIL static%0b_strobes got %0d want 0", level, (validCnt - v0) + (errCnt - e0));
      else passCnt++;
      rf_in = 1'b0;
   endtask

   task automatic test_edge_threshold();
      idleWindows(2);
      sendPattern(PAT_3EDGE);
      totalCnt++;
      if (bus.carrier !== 1'b0) $display("[TB] FAIL edges3_carrier got %b want 0", bus.carrier);
      else passCnt++;
      sendPattern(PAT_3LATE);
      totalCnt++;
      if (bus.carrier !== 1'b0) $display("[TB] FAIL edges3late_carrier got %b want 0", bus.carrier);
      else passCnt++;
      // Fourth rise is counted on the window's last cycle
      sendPattern(PAT_4LATE);
      totalCnt++;
      if (bus.carrier !== 1'b1) $display("[TB] FAIL edge15_carrier got %b want 1", bus.carrier);
      else passCnt++;
      sendPattern(PAT_OFF);
      totalCnt++;
      if (bus.carrier !== 1'b0) $display("[TB] FAIL after_off_carrier got %b want 0", bus.carrier);
      else passCnt++;
      for (int w = 0; w < 6; w++) sendPattern(PAT_OFF);
   endtask

   task automatic test_glitch_reject();
      int b0, v0, e0;
      idleWindows(2);
      b0 = busyCnt;
      v0 = validCnt;
      e0 = errCnt;
      sendPattern(PAT_ON);
      for (int w = 0; w < 5; w++) sendPattern(PAT_OFF);
      // Detecting window is spent in IDLE, START then spans the other 3 slot windows
      totalCnt++;
      if (busyCnt - b0 !== 3 * WIN_LEN)
         $display("[TB] FAIL glitch_busy_cycles got %0d want %0d", busyCnt - b0, 3 * WIN_LEN);
      else passCnt++;
      totalCnt++;
      if (bus.busy !== 1'b0) $display("[TB] FAIL glitch_busy_end got %b want 0", bus.busy);
      else passCnt++;
      totalCnt++;
      if ((validCnt - v0) + (errCnt - e0) !== 0)
         $display("[TB] FAIL glitch_strobes got %0d want 0", (validCnt - v0) + (errCnt - e0));
      else passCnt++;
   endtask

   task automatic test_good_frame(input logic [7:0] b, input string tag);
      int v0, e0;
      idleWindows(2);
      v0 = validCnt;
      e0 = errCnt;
      sendFrame(b, 1'b0);
      @(negedge CLK1);
      totalCnt++;
      if (bus.data_valid !== 1'b1) $display("[TB] FAIL %s_valid got %b want 1", tag, bus.data_valid);
      else passCnt++;
      totalCnt++;
      if (bus.data !== b) $display("[TB] FAIL %s_data got %h want %h", tag, bus.data, b);
      else passCnt++;
      totalCnt++;
      if (bus.busy !== 1'b0) $display("[TB] FAIL %s_busy got %b want 0", tag, bus.busy);
      else passCnt++;
      @(negedge CLK1);
      totalCnt++;
      if (bus.data_valid !== 1'b0) $display("[TB] FAIL %s_valid_width got %b want 0", tag, bus.data_valid);
      else passCnt++;
      idleWindows(4);
      totalCnt++;
      if (validCnt - v0 !== 1) $display("[TB] FAIL %s_valid_count got %0d want 1", tag, validCnt - v0);
      else passCnt++;
      totalCnt++;
      if (errCnt - e0 !== 0) $display("[TB] FAIL %s_err_count got %0d want 0", tag, errCnt - e0);
      else passCnt++;
   endtask

   task automatic test_frame_error();
      int v0, e0;
      idleWindows(2);
      v0 = validCnt;
      e0 = errCnt;
      sendFrame(8'h3C, 1'b1);
      @(negedge CLK1);
      totalCnt++;
      if (bus.frame_err !== 1'b1) $display("[TB] FAIL ferr_strobe got %b want 1", bus.frame_err);
      else passCnt++;
      totalCnt++;
      if (bus.data !== 8'hA5) $display("[TB] FAIL ferr_data_kept got %h want a5", bus.data);
      else passCnt++;
      @(negedge CLK1);
      totalCnt++;
      if (bus.frame_err !== 1'b0) $display("[TB] FAIL ferr_width got %b want 0", bus.frame_err);
      else passCnt++;
      idleWindows(4);
      totalCnt++;
      if (errCnt - e0 !== 1) $display("[TB] FAIL ferr_count got %0d want 1", errCnt - e0);
      else passCnt++;
      totalCnt++;
      if (validCnt - v0 !== 0) $display("[TB] FAIL ferr_valid_count got %0d want 0", validCnt - v0);
      else passCnt++;
   endtask

   task automatic test_reset_mid_frame();
      int v0, e0;
      idleWindows(2);
      v0 = validCnt;
      e0 = errCnt;
      sendSlot(1'b1);
      sendSlot(1'b0);
      sendSlot(1'b0);
      totalCnt++;
      if (bus.busy !== 1'b1) $display("[TB] FAIL mid_busy_before got %b want 1", bus.busy);
      else passCnt++;
      RST = 1'b1;
      #1;
      totalCnt++;
      if (bus.data !== 8'h00) $display("[TB] FAIL mid_rst_data got %h want 00", bus.data);
      else passCnt++;
      totalCnt++;
      if (bus.busy !== 1'b0) $display("[TB] FAIL mid_rst_busy got %b want 0", bus.busy);
      else passCnt++;
      totalCnt++;
      if (bus.carrier !== 1'b0) $display("[TB] FAIL mid_rst_carrier got %b want 0", bus.carrier);
      else passCnt++;
      repeat (3) @(negedge CLK1);
      RST = 1'b0;
      totalCnt++;
      if ((validCnt - v0) + (errCnt - e0) !== 0)
         $display("[TB] FAIL mid_rst_strobes got %0d want 0", (validCnt - v0) + (errCnt - e0));
      else passCnt++;
      test_good_frame(8'h3C, "post_rst");
   endtask

   initial begin
      test_reset();
      test_static(1'b0);
      test_static(1'b1);
      test_static(1'b0);
      test_edge_threshold();
      test_glitch_reject();
      test_good_frame(8'hA5, "frameA5");
      test_frame_error();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
